// File: rtl/radix_8_intt_pipe.sv
// Radix-8 inverse NTT: three Gentleman-Sande butterfly stages plus a psi^-1 post-weight stage, 4-cycle latency.
// Optional macro RADIX_8_INTT_PIPE_SCALE_EN folds the 1/8 (N_INV) scaling into the post-weight stage.
module radix_8_intt_pipe #(
  parameter int WIDTH = 18,
  parameter int Q     = 12289,
  parameter int N_INV = 10753
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  input  logic [WIDTH-1:0] input_3,
  input  logic [WIDTH-1:0] input_4,
  input  logic [WIDTH-1:0] input_5,
  input  logic [WIDTH-1:0] input_6,
  input  logic [WIDTH-1:0] input_7,
  input  logic [WIDTH-1:0] input_8,
  input  logic [WIDTH-1:0] winv_1_8,
  input  logic [WIDTH-1:0] winv_2_8,
  input  logic [WIDTH-1:0] winv_3_8,
  input  logic [WIDTH-1:0] psi_inv_1,
  input  logic [WIDTH-1:0] psi_inv_2,
  input  logic [WIDTH-1:0] psi_inv_3,
  input  logic [WIDTH-1:0] psi_inv_4,
  input  logic [WIDTH-1:0] psi_inv_5,
  input  logic [WIDTH-1:0] psi_inv_6,
  input  logic [WIDTH-1:0] psi_inv_7,
  input  logic [WIDTH-1:0] psi_inv_8,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_1,
  output logic [WIDTH-1:0] output_2,
  output logic [WIDTH-1:0] output_3,
  output logic [WIDTH-1:0] output_4,
  output logic [WIDTH-1:0] output_5,
  output logic [WIDTH-1:0] output_6,
  output logic [WIDTH-1:0] output_7,
  output logic [WIDTH-1:0] output_8
);

  localparam logic [WIDTH:0]     Q_EXT  = (WIDTH+1)'(Q);
  localparam logic [2*WIDTH-1:0] Q_WIDE = (2*WIDTH)'(Q);

  if (Q < 2 || Q >= (1 << WIDTH) || N_INV >= Q) begin : g_bad_params
    $error("radix_8_intt_pipe: Q must fit in WIDTH bits and N_INV must be below Q");
  end

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= Q_EXT) ? WIDTH'(s - Q_EXT) : WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (a >= b) ? WIDTH'({1'b0, a} - {1'b0, b}) : WIDTH'({1'b0, a} + Q_EXT - {1'b0, b});
  endfunction

  // Full 2*WIDTH product is formed before the reduction.
  function automatic logic [WIDTH-1:0] mul_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return WIDTH'(({{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b}) % Q_WIDE);
  endfunction

  logic             advance;
  logic [WIDTH-1:0] in_lane  [8];
  logic [WIDTH-1:0] psi_lane [8];
  logic [WIDTH-1:0] tw1      [1:3];
  logic [WIDTH-1:0] s1_next  [8];
  logic [WIDTH-1:0] s2_next  [8];
  logic [WIDTH-1:0] s3_next  [8];
  logic [WIDTH-1:0] s4_next  [8];
  logic [WIDTH-1:0] s1_reg   [8];
  logic [WIDTH-1:0] s2_reg   [8];
  logic [WIDTH-1:0] s3_reg   [8];
  logic [WIDTH-1:0] s4_reg   [8];
  logic             s1_valid_reg;
  logic             s2_valid_reg;
  logic             s3_valid_reg;
  logic             s4_valid_reg;

  assign advance  = out_ready | ~s4_valid_reg;
  assign in_ready = advance;

  assign in_lane  = '{input_1, input_2, input_3, input_4, input_5, input_6, input_7, input_8};
  assign psi_lane = '{psi_inv_1, psi_inv_2, psi_inv_3, psi_inv_4,
                      psi_inv_5, psi_inv_6, psi_inv_7, psi_inv_8};
  assign tw1      = '{winv_1_8, winv_2_8, winv_3_8};

  genvar gi;

  // Stage 1: span-4 butterflies on the incoming vector; lane 0's twiddle is 1, so no multiplier there.
  for (gi = 0; gi < 4; gi++) begin : g_stage1
    assign s1_next[gi] = add_mod(in_lane[gi], in_lane[gi+4]);
    if (gi == 0) begin : g_unit
      assign s1_next[gi+4] = sub_mod(in_lane[gi], in_lane[gi+4]);
    end else begin : g_twiddle
      assign s1_next[gi+4] = mul_mod(sub_mod(in_lane[gi], in_lane[gi+4]), tw1[gi]);
    end
  end

  // Stage 2: span-2 butterflies; the odd pair in each half uses w^-2.
  for (gi = 0; gi < 4; gi++) begin : g_stage2
    localparam int LO = (gi / 2) * 4 + (gi % 2);
    assign s2_next[LO] = add_mod(s1_reg[LO], s1_reg[LO+2]);
    if (gi % 2 == 0) begin : g_unit
      assign s2_next[LO+2] = sub_mod(s1_reg[LO], s1_reg[LO+2]);
    end else begin : g_twiddle
      assign s2_next[LO+2] = mul_mod(sub_mod(s1_reg[LO], s1_reg[LO+2]), winv_2_8);
    end
  end

  for (gi = 0; gi < 4; gi++) begin : g_stage3
    assign s3_next[2*gi]   = add_mod(s3_in(2*gi), s3_in(2*gi+1));
    assign s3_next[2*gi+1] = sub_mod(s3_in(2*gi), s3_in(2*gi+1));
  end

  function automatic logic [WIDTH-1:0] s3_in(input int idx);
    return s2_reg[idx];
  endfunction

  // Stage 4: bit-reversed gather into natural order, then the psi^-1 weight (and optional 1/8).
  for (gi = 0; gi < 8; gi++) begin : g_stage4
    localparam int BR = ((gi & 1) << 2) | (gi & 2) | ((gi >> 2) & 1);
`ifdef RADIX_8_INTT_PIPE_SCALE_EN
    localparam logic [WIDTH-1:0] N_INV_W = WIDTH'(N_INV);
    assign s4_next[gi] = mul_mod(mul_mod(s3_reg[BR], psi_lane[gi]), N_INV_W);
`else
    assign s4_next[gi] = mul_mod(s3_reg[BR], psi_lane[gi]);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      s4_valid_reg <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        s1_reg[i] <= '0;
        s2_reg[i] <= '0;
        s3_reg[i] <= '0;
        s4_reg[i] <= '0;
      end
    end else if (advance) begin
      s1_valid_reg <= in_valid;
      s2_valid_reg <= s1_valid_reg;
      s3_valid_reg <= s2_valid_reg;
      s4_valid_reg <= s3_valid_reg;
      s1_reg       <= s1_next;
      s2_reg       <= s2_next;
      s3_reg       <= s3_next;
      s4_reg       <= s4_next;
    end
  end

  assign out_valid = s4_valid_reg;
  assign output_1  = s4_reg[0];
  assign output_2  = s4_reg[1];
  assign output_3  = s4_reg[2];
  assign output_4  = s4_reg[3];
  assign output_5  = s4_reg[4];
  assign output_6  = s4_reg[5];
  assign output_7  = s4_reg[6];
  assign output_8  = s4_reg[7];

endmodule

// File: tb/tb_radix_8_intt_pipe.sv
// Directed and random-stream bench for radix_8_intt_pipe (expectations follow RADIX_8_INTT_PIPE_SCALE_EN).
module tb_radix_8_intt_pipe;
  localparam int WIDTH = 18;
  localparam int Q     = 12289;
  localparam int N_INV = 10753;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] in_d  [8];
  logic [WIDTH-1:0] psi   [8];
  logic [WIDTH-1:0] out_d [8];
  logic [WIDTH-1:0] w1, w2, w3;
  logic [8*WIDTH-1:0] in_bus, out_bus;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  longint wpow [8];
  logic [8*WIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  assign in_bus  = {in_d[7], in_d[6], in_d[5], in_d[4], in_d[3], in_d[2], in_d[1], in_d[0]};
  assign out_bus = {out_d[7], out_d[6], out_d[5], out_d[4], out_d[3], out_d[2], out_d[1], out_d[0]};

  radix_8_intt_pipe #(.WIDTH(WIDTH), .Q(Q), .N_INV(N_INV)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .input_1(in_d[0]), .input_2(in_d[1]), .input_3(in_d[2]), .input_4(in_d[3]),
    .input_5(in_d[4]), .input_6(in_d[5]), .input_7(in_d[6]), .input_8(in_d[7]),
    .winv_1_8(w1), .winv_2_8(w2), .winv_3_8(w3),
    .psi_inv_1(psi[0]), .psi_inv_2(psi[1]), .psi_inv_3(psi[2]), .psi_inv_4(psi[3]),
    .psi_inv_5(psi[4]), .psi_inv_6(psi[5]), .psi_inv_7(psi[6]), .psi_inv_8(psi[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .output_1(out_d[0]), .output_2(out_d[1]), .output_3(out_d[2]), .output_4(out_d[3]),
    .output_5(out_d[4]), .output_6(out_d[5]), .output_7(out_d[6]), .output_8(out_d[7])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [8*WIDTH-1:0] obs, input logic [8*WIDTH-1:0] expv);
    total_cnt++;
    assert (obs === expv) begin
      pass_cnt++;
      $display("check %s ok: %0h", tag, obs);
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    total_cnt++;
    assert (obs === expv) begin
      pass_cnt++;
      $display("check %s ok: %0d", tag, obs);
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic longint modpow(input longint b, input int e);
    longint r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % Q;
    return r;
  endfunction

  // Output scaling as the build configures it.
  function automatic int sc(input int v);
`ifdef RADIX_8_INTT_PIPE_SCALE_EN
    return int'((longint'(v) * N_INV) % Q);
`else
    return v;
`endif
  endfunction

  function automatic logic [8*WIDTH-1:0] lanes(input int l0, l1, l2, l3, l4, l5, l6, l7);
    return {WIDTH'(sc(l7)), WIDTH'(sc(l6)), WIDTH'(sc(l5)), WIDTH'(sc(l4)),
            WIDTH'(sc(l3)), WIDTH'(sc(l2)), WIDTH'(sc(l1)), WIDTH'(sc(l0))};
  endfunction

  // Reference: direct 8-point inverse transform X_i = psi_i * sum_j x_j * W^(i*j) mod Q.
  function automatic logic [8*WIDTH-1:0] model(input logic [8*WIDTH-1:0] x);
    logic [8*WIDTH-1:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      longint acc = 0;
      for (int j = 0; j < 8; j++)
        acc = (acc + longint'(x[j*WIDTH +: WIDTH]) * wpow[(i*j) % 8]) % Q;
      acc = (acc * longint'(psi[i])) % Q;
      r[i*WIDTH +: WIDTH] = WIDTH'(sc(int'(acc)));
    end
    return r;
  endfunction

  task automatic set_in(input int l0, l1, l2, l3, l4, l5, l6, l7);
    in_d = '{WIDTH'(l0), WIDTH'(l1), WIDTH'(l2), WIDTH'(l3), WIDTH'(l4), WIDTH'(l5), WIDTH'(l6), WIDTH'(l7)};
  endtask

  // Push one vector and check the exact 4-cycle latency and the result.
  task automatic run_one(input string tag, input logic [8*WIDTH-1:0] expv);
    in_valid = 1'b1;
    check_int({tag, "_in_ready"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check_int({tag, "_not_early"}, int'(out_valid), 0);
    tick();
    check_int({tag, "_out_valid"}, int'(out_valid), 1);
    check_vec({tag, "_data"}, out_bus, expv);
    tick();
  endtask

  initial begin
    int acc_n, stale, sent, rcvd, cyc, g;
    logic rdy;
    longint w;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    w1 = 1; w2 = 1; w3 = 1;
    for (int k = 0; k < 8; k++) psi[k] = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check_int("reset_out_valid", int'(out_valid), 0);
    check_vec("reset_outputs", out_bus, '0);
    check_int("reset_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    tick();

    // Directed vectors with hand-derived results.
    set_in(1, 1, 1, 1, 1, 1, 1, 1);
    run_one("constant", lanes(8, 0, 0, 0, 0, 0, 0, 0));
    set_in(5, 0, 0, 0, 0, 0, 0, 0);
    run_one("impulse", lanes(5, 5, 5, 5, 5, 5, 5, 5));
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    run_one("wrap", lanes(1, 12288, 1, 12288, 1, 12288, 1, 12288));

    // Backpressure: only four vectors fit while the output is stalled.
    out_ready = 1'b0;
    in_valid = 1'b1;
    acc_n = 0;
    for (int k = 0; k < 6; k++) begin
      set_in(acc_n + 1, 0, 0, 0, 0, 0, 0, 0);
      rdy = in_ready;
      tick();
      if (rdy) acc_n++;
    end
    check_int("bp_accepted", acc_n, 4);
    check_int("bp_in_ready_low", int'(in_ready), 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check_int("bp_in_ready_back", int'(in_ready), 1);
    for (int k = 0; k < 4; k++) begin
      check_int($sformatf("bp_valid_%0d", k), int'(out_valid), 1);
      check_vec($sformatf("bp_data_%0d", k), out_bus, lanes(k+1, k+1, k+1, k+1, k+1, k+1, k+1, k+1));
      tick();
    end
    check_int("bp_drained", int'(out_valid), 0);

    // Asynchronous reset with three vectors in flight.
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(7 + k, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_int("rst_pre_valid", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("rst_async_valid", int'(out_valid), 0);
    check_vec("rst_async_data", out_bus, '0);
    tick();
    tick();
    rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) stale++;
    end
    check_int("rst_no_stale", stale, 0);

    // Random stream with a true primitive 8th root of unity and random psi^-1 weights.
    w = 1;
    g = 2;
    while (g < 200) begin
      w = modpow(longint'(g), (Q - 1) / 8);
      if (modpow(w, 4) == longint'(Q - 1)) break;
      g++;
    end
    for (int k = 0; k < 8; k++) wpow[k] = modpow(w, k);
    w1 = WIDTH'(wpow[1]); w2 = WIDTH'(wpow[2]); w3 = WIDTH'(wpow[3]);
    for (int k = 0; k < 8; k++) psi[k] = WIDTH'($urandom_range(1, Q - 1));

    sent = 0; rcvd = 0; cyc = 0;
    while ((sent < 100 || rcvd < sent) && cyc < 3000) begin
      in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 8; k++) in_d[k] = WIDTH'($urandom_range(0, Q - 1));
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_bus));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) check_vec($sformatf("stream_%0d", rcvd), out_bus, exp_q.pop_front());
        rcvd++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check_int("stream_received", rcvd, 100);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
